// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache between the fetch port and the memory controller.
// Hits are served combinationally in IDLE; a miss parks in MISS until the controller drops iwait.
module icache #(
  parameter int NUM_SETS = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic [31:0]      imemload,
  output logic             ihit,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             state_dbg
);

  localparam int IDXW = $clog2(NUM_SETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  // Handshake: iREN/iaddr stay stable through MISS; the first cycle with iwait low
  // carries valid iload and is the fill cycle. ihit qualifies imemload in the same cycle.

  state_t              state, state_nxt;
  logic [NUM_SETS-1:0] valid;
  logic [TAGW-1:0]     tag_arr  [NUM_SETS];
  logic [31:0]         data_arr [NUM_SETS];
  logic [29:0]         miss_word;

  logic [IDXW-1:0] idx, miss_idx;
  logic [TAGW-1:0] tag, miss_tag;
  logic            hit, fill, miss_take;
  logic [1:0]      unused_byte_off;

  assign idx             = imemaddr[2+IDXW-1:2];
  assign tag             = imemaddr[31:2+IDXW];
  assign miss_idx        = miss_word[IDXW-1:0];
  assign miss_tag        = miss_word[29:IDXW];
  assign unused_byte_off = imemaddr[1:0];
  assign state_dbg       = state;

  assign hit  = (state == IDLE) && imemREN && valid[idx] && (tag_arr[idx] == tag);
  assign fill = (state == MISS) && !iwait;

  always_comb begin
    state_nxt = state;
    ihit      = 1'b0;
    imemload  = 32'h0;
    iREN      = 1'b0;
    iaddr     = 32'h0;
    miss_take = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_arr[idx];
        end else if (imemREN) begin
          miss_take = 1'b1;
          state_nxt = MISS;
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = {miss_word, 2'b00};
        if (!iwait) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_word <= 30'h0;
    end else begin
      state <= state_nxt;
      if (miss_take) miss_word <= imemaddr[31:2];
    end
  end

  // Flush clears first so a fill in the same cycle still leaves its set valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else begin
      if (flush) valid <= '0;
      if (fill)  valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= 32'h0;
      end
    end else if (fill) begin
      tag_arr[miss_idx]  <= miss_tag;
      data_arr[miss_idx] <= iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != '1))        hit_count  <= hit_count + CNT_W'(1);
      if (miss_take && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: drivers push expected fetch data and memory requests into
// queues; a negedge monitor pops and compares whenever the cache presents ihit or iREN.
module tb_icache;

  localparam int CW = 4;

  logic          clk, nrst;
  logic          imemren, flush, iren, ihit, iwait, state_dbg;
  logic [31:0]   imemaddr, imemload, iaddr, iload;
  logic [CW-1:0] hit_count, miss_count;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_len_q[$];

  int n_cmp = 0;
  int n_err = 0;

  icache #(.NUM_SETS(16), .CNT_W(CW)) dut (
    .CLK(clk), .nRST(nrst), .imemREN(imemren), .imemaddr(imemaddr), .imemload(imemload),
    .ihit(ihit), .flush(flush), .iREN(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, time=%0t required=before 200000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] data, input int k);
    imemren  = 1'b1;
    imemaddr = addr;
    repeat (k) begin
      exp_q.push_back(data);
      cyc();
    end
  endtask

  // Miss with n cycles of iREN; the last of them is the fill cycle, optionally with flush.
  task automatic miss(input logic [31:0] addr, input logic [31:0] data, input int n,
                      input logic fl = 1'b0);
    imemren  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    exp_addr_q.push_back(addr);
    exp_len_q.push_back(n);
    cyc();
    repeat (n - 1) cyc();
    iwait = 1'b0;
    iload = data;
    flush = fl;
    cyc();
    iwait = 1'b1;
    iload = 32'h0;
    flush = 1'b0;
  endtask

  task automatic idle(input int k);
    imemren = 1'b0;
    cyc(k);
  endtask

  // scoreboard monitor
  logic [31:0] cur_addr;
  int          run_len;
  logic        prev_ren;

  initial begin
    prev_ren = 1'b0;
    run_len  = 0;
    cur_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_ren = 1'b0;
        run_len  = 0;
      end else begin
        if (ihit) begin
          if (exp_q.size() == 0) check("unexpected_ihit", 32'(ihit), 32'h0);
          else check("imemload", imemload, exp_q.pop_front());
        end
        if (iren) begin
          if (!prev_ren) begin
            run_len = 0;
            if (exp_addr_q.size() == 0) check("unexpected_iren", 32'(iren), 32'h0);
            else cur_addr = exp_addr_q.pop_front();
          end
          check("iaddr", iaddr, cur_addr);
          run_len++;
        end else if (prev_ren) begin
          if (exp_len_q.size() == 0) check("iren_len_unexpected", 32'(run_len), 32'h0);
          else check("iren_len", 32'(run_len), exp_len_q.pop_front());
        end
        prev_ren = iren;
      end
    end
  end

  initial begin
    nrst = 1'b0; imemren = 1'b0; imemaddr = 32'h0; flush = 1'b0;
    iwait = 1'b1; iload = 32'h0;
    cyc(2);
    check("rst_ihit", 32'(ihit), 32'h0);
    check("rst_iren", 32'(iren), 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_hits", 32'(hit_count), 32'h0);
    check("rst_misses", 32'(miss_count), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    nrst = 1'b1;
    cyc();

    // 1: cold miss, iREN held 3 cycles, then hit
    miss(32'h40, 32'h2001_0005, 3);
    hit(32'h40, 32'h2001_0005, 1);
    check("t1_misses", 32'(miss_count), 32'd1);
    check("t1_hits", 32'(hit_count), 32'd1);

    // 2: repeated hits; byte offset bits must be ignored
    hit(32'h40, 32'h2001_0005, 4);
    hit(32'h43, 32'h2001_0005, 1);
    check("t2_hits", 32'(hit_count), 32'd6);
    idle(1);
    check("idle_imemload", imemload, 32'h0);

    // 3: conflict on index 0, minimum latency fill
    miss(32'h80, 32'h8C01_0080, 1);
    hit(32'h80, 32'h8C01_0080, 1);
    miss(32'h40, 32'h2001_0006, 2);
    hit(32'h40, 32'h2001_0006, 1);
    check("t3_misses", 32'(miss_count), 32'd3);
    check("t3_hits", 32'(hit_count), 32'd8);

    // 4: address changes during MISS; fill completes for the latched address
    imemren = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
    imemren = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    exp_addr_q.push_back(32'h40); exp_len_q.push_back(3);
    cyc();
    imemaddr = 32'h44;
    cyc();
    cyc();
    iwait = 1'b0; iload = 32'h2001_0007;
    cyc();
    iwait = 1'b1; iload = 32'h0;
    check("t4_state_after_fill", 32'(state_dbg), 32'h0);
    miss(32'h44, 32'h0044_0044, 1);
    hit(32'h44, 32'h0044_0044, 1);
    hit(32'h40, 32'h2001_0007, 1);
    check("t4_misses", 32'(miss_count), 32'd5);
    check("t4_hits", 32'(hit_count), 32'd10);

    // 5: flush coincident with fill of 0x84 keeps 0x84, drops 0x40
    miss(32'h84, 32'h0084_0084, 1, 1'b1);
    hit(32'h84, 32'h0084_0084, 1);
    flush = 1'b1;
    hit(32'h84, 32'h0084_0084, 1);
    flush = 1'b0;
    check("t5_hits_flush", 32'(hit_count), 32'd12);
    miss(32'h40, 32'h2001_0008, 1);
    hit(32'h40, 32'h2001_0008, 1);
    miss(32'h84, 32'h0084_0085, 2);
    hit(32'h84, 32'h0084_0085, 1);
    check("t5_misses", 32'(miss_count), 32'd8);
    check("t5_hits", 32'(hit_count), 32'd14);

    // 6: async reset in MISS
    hit(32'h40, 32'h2001_0008, 1);
    imemaddr = 32'h48; iwait = 1'b1;
    exp_addr_q.push_back(32'h48);
    cyc(3);
    #2;
    nrst = 1'b0;
    #1;
    check("t6_iren_rst", 32'(iren), 32'h0);
    check("t6_iaddr_rst", iaddr, 32'h0);
    check("t6_misses_rst", 32'(miss_count), 32'h0);
    imemren = 1'b0;
    cyc(2);
    nrst = 1'b1;
    cyc();
    miss(32'h40, 32'h2001_0009, 2);
    hit(32'h40, 32'h2001_0009, 1);
    check("t6_misses", 32'(miss_count), 32'd1);
    check("t6_hits", 32'(hit_count), 32'd1);

    // hit counter saturates at all-ones
    hit(32'h40, 32'h2001_0009, 20);
    check("sat_hits", 32'(hit_count), 32'd15);
    idle(3);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
    check("exp_len_q_empty", 32'(exp_len_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
